rr_arb2_1: RTL and testbench

- Two-input round-robin arbiter with valid/ready handshakes and a one-entry registered output.
- Sits directly upstream of the 2:1 mux. Its sel output drives the mux select, and its registered data output carries the selected word to the consumer.
- Converts the free-running mux select into a fair, flow-controlled stream merge.

---
 rtl/rr_arb2_1_pkg.sv | 15 +
 rtl/rr_arb2_1_grant.sv | 25 ++
 rtl/rr_arb2_1.sv | 103 ++++++++++
 tb/tb_rr_arb2_1.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb2_1_pkg.sv
// Shared constants and types for the two-input round-robin arbiter rr_arb2_1.
package rr_arb2_1_pkg;

   localparam logic SEL_IN1 = 1'b1;
   localparam logic SEL_IN2 = 1'b0;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arb2_1_grant.sv
// arb2_grant: combinational round-robin grant and ready generation.
// The ready outputs depend only on valids, last_grant and load_en, never on data.
module arb2_grant
   import rr_arb2_1_pkg::*;
(
   input  logic in1_valid,
   input  logic in2_valid,
   input  logic last_grant,
   input  logic load_en,
   output logic grant_vld,
   output logic grant_src,
   output logic in1_ready,
   output logic in2_ready
);

   always_comb begin
      grant_vld = in1_valid | in2_valid;
      grant_src = SEL_IN2;
      if (in1_valid && in2_valid) grant_src = ~last_grant;
      else if (in1_valid)         grant_src = SEL_IN1;
      in1_ready = load_en & grant_vld & (grant_src == SEL_IN1);
      in2_ready = load_en & grant_vld & (grant_src == SEL_IN2);
   end

endmodule

// File: rtl/rr_arb2_1.sv
// rr_arb2_1: two-input round-robin arbiter with a one-entry registered output.
// Optional per-input saturating grant counters when RR_ARB2_1_CNT_EN is defined.
module rr_arb2_1
   import rr_arb2_1_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   output logic              in1_ready,
   input  logic              in2_valid,
   input  logic [DATA_W-1:0] in2_data,
   output logic              in2_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
`ifdef RR_ARB2_1_CNT_EN
   output logic [CNT_W-1:0]  gnt1_cnt,
   output logic [CNT_W-1:0]  gnt2_cnt,
`endif
   output logic              sel
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic              sel_q;
   logic              last_q;
   logic              load_en;
   logic              grant_vld;
   logic              grant_src;
   logic              xfer;

   assign load_en = ~out_valid | out_ready;
   assign xfer    = grant_vld & load_en;

   arb2_grant u_grant (
      .in1_valid (in1_valid),
      .in2_valid (in2_valid),
      .last_grant(last_q),
      .load_en   (load_en),
      .grant_vld (grant_vld),
      .grant_src (grant_src),
      .in1_ready (in1_ready),
      .in2_ready (in2_ready)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_EMPTY;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (grant_vld) state_d = ST_FULL;
         ST_FULL:  if (out_ready && !grant_vld) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q == ST_FULL);
   end

   // Priority only rotates on an accepted word, so a stalled output keeps it.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         data_q <= '0;
         sel_q  <= SEL_IN2;
         last_q <= SEL_IN2;
      end else if (xfer) begin
         data_q <= (grant_src == SEL_IN1) ? in1_data : in2_data;
         sel_q  <= grant_src;
         last_q <= grant_src;
      end
   end

   assign out_data = data_q;
   assign sel      = sel_q;

`ifdef RR_ARB2_1_CNT_EN
   logic [CNT_W-1:0] cnt1_q, cnt2_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else if (xfer) begin
         if (grant_src == SEL_IN1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
         if (grant_src == SEL_IN2 && cnt2_q != '1) cnt2_q <= cnt2_q + 1'b1;
      end
   end

   assign gnt1_cnt = cnt1_q;
   assign gnt2_cnt = cnt2_q;
`else
   wire [CNT_W-1:0] unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_rr_arb2_1.sv
// Directed bench for rr_arb2_1; counter checks run only with RR_ARB2_1_CNT_EN.
module tb_rr_arb2_1;

   localparam int DATA_W = 8;
`ifdef RR_ARB2_1_CNT_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 16;
`endif

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic              in1_valid, in2_valid, out_ready;
   logic [DATA_W-1:0] in1_data, in2_data;
   logic              in1_ready, in2_ready, out_valid, sel;
   logic [DATA_W-1:0] out_data;
`ifdef RR_ARB2_1_CNT_EN
   logic [CNT_W-1:0]  gnt1_cnt, gnt2_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 sys_clk = ~sys_clk;

   rr_arb2_1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .in1_valid(in1_valid),
      .in1_data (in1_data),
      .in1_ready(in1_ready),
      .in2_valid(in2_valid),
      .in2_data (in2_data),
      .in2_ready(in2_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
`ifdef RR_ARB2_1_CNT_EN
      .gnt1_cnt (gnt1_cnt),
      .gnt2_cnt (gnt2_cnt),
`endif
      .sel      (sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".out_data"},  32'(out_data),  32'd0);
      chk({tag, ".sel"},       32'(sel),       32'd0);
      chk({tag, ".in1_ready"}, 32'(in1_ready), 32'd0);
      chk({tag, ".in2_ready"}, 32'(in2_ready), 32'd0);
   endtask

   initial begin
      sys_rst = 1'b1;
      in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
      in1_data = '0; in2_data = '0;
      #1 chk_idle("reset");
      #19 sys_rst = 1'b0;
      repeat (10) begin
         cyc();
         chk_idle("idle");
      end

      // single requester in1, then in2 to leave last_grant = in2
      in1_valid = 1'b1; in1_data = 8'hA5; out_ready = 1'b1;
      #1 chk("single1.in1_ready", 32'(in1_ready), 32'd1);
      chk("single1.in2_ready", 32'(in2_ready), 32'd0);
      cyc();
      in1_valid = 1'b0;
      chk("single1.out_valid", 32'(out_valid), 32'd1);
      chk("single1.out_data",  32'(out_data),  32'hA5);
      chk("single1.sel",       32'(sel),       32'd1);
      in2_valid = 1'b1; in2_data = 8'h33;
      #1 chk("single2.in2_ready", 32'(in2_ready), 32'd1);
      chk("single2.in1_ready", 32'(in1_ready), 32'd0);
      cyc();
      chk("single2.out_data", 32'(out_data), 32'h33);
      chk("single2.sel",      32'(sel),      32'd0);

      // contention: expect 11,22,11,22,11,22
      in1_valid = 1'b1; in1_data = 8'h11;
      in2_valid = 1'b1; in2_data = 8'h22;
      for (int i = 0; i < 6; i++) begin
         #1 chk("alt.in1_ready", 32'(in1_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt.in2_ready", 32'(in2_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         cyc();
         chk("alt.out_valid", 32'(out_valid), 32'd1);
         chk("alt.out_data",  32'(out_data),  (i % 2 == 0) ? 32'h11 : 32'h22);
         chk("alt.sel",       32'(sel),       (i % 2 == 0) ? 32'd1 : 32'd0);
      end

      // backpressure: 22 held, no readys, no rotation
      out_ready = 1'b0;
      repeat (5) begin
         #1 chk("bp.in1_ready", 32'(in1_ready), 32'd0);
         chk("bp.in2_ready", 32'(in2_ready), 32'd0);
         cyc();
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.out_data",  32'(out_data),  32'h22);
         chk("bp.sel",       32'(sel),       32'd0);
      end
      out_ready = 1'b1;
      #1 chk("bp_rel.in1_ready", 32'(in1_ready), 32'd1);
      chk("bp_rel.in2_ready", 32'(in2_ready), 32'd0);
      cyc();
      chk("bp_rel.out_data", 32'(out_data), 32'h11);
      chk("bp_rel.sel",      32'(sel),      32'd1);

      // async reset between edges while full; in1 favoured afterwards
      #2 sys_rst = 1'b1;
      #1 chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.out_data", 32'(out_data), 32'd0);
      chk("arst.sel",      32'(sel),      32'd0);
      cyc();
      chk("arst_hold.out_valid", 32'(out_valid), 32'd0);
      #2 sys_rst = 1'b0;
      #1 chk("post_rst.in1_ready", 32'(in1_ready), 32'd1);
      chk("post_rst.in2_ready", 32'(in2_ready), 32'd0);
      cyc();
      chk("post_rst.out_data", 32'(out_data), 32'h11);
      chk("post_rst.sel",      32'(sel),      32'd1);
      #1 chk("post_rst2.in2_ready", 32'(in2_ready), 32'd1);
      cyc();
      chk("post_rst2.out_data", 32'(out_data), 32'h22);
      chk("post_rst2.sel",      32'(sel),      32'd0);

`ifdef RR_ARB2_1_CNT_EN
      in1_valid = 1'b0; in2_valid = 1'b0;
      #2 sys_rst = 1'b1;
      #1 chk("cnt_rst.gnt1", 32'(gnt1_cnt), 32'd0);
      chk("cnt_rst.gnt2", 32'(gnt2_cnt), 32'd0);
      sys_rst = 1'b0;
      in1_valid = 1'b1; in2_valid = 1'b1;
      repeat (10) cyc();
      in1_valid = 1'b0; in2_valid = 1'b0;
      chk("cnt_alt.gnt1", 32'(gnt1_cnt), 32'd5);
      chk("cnt_alt.gnt2", 32'(gnt2_cnt), 32'd5);
      in1_valid = 1'b1;
      repeat (20) cyc();
      in1_valid = 1'b0;
      chk("cnt_sat.gnt1", 32'(gnt1_cnt), 32'hF);
      chk("cnt_sat.gnt2", 32'(gnt2_cnt), 32'd5);
`endif

      in1_valid = 1'b0; in2_valid = 1'b0;
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
